arb_rr_scheduler: RTL and testbench

Round-robin arbiter that shares one resource among C_NUM_REQ requesters over the arb REQ/GNT/REL handshake. Each requester connects through an arb slave port. The block issues at most one registered one-hot grant and guarantees one idle cycle between owners. When other requesters are waiting, it forces a hand-off by asserting REL to an owner that has held the grant for C_MAX_HOLD cycles. It sits in front of wirethrough-connected arb interfaces and is the single grant authority for the shared resource.

---
 rtl/arb_rr_scheduler.sv | 148 ++++++++++++++
 tb/tb_arb_rr_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_scheduler.sv
// Round-robin grant authority for one shared resource over the REQ/GNT/REL handshake.
// Registered one-hot grant, one idle cycle between owners, REL-based preemption after C_MAX_HOLD.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no grant; pick next requester from r_ptr up
// ST_BUSY    | grant held, counting contended cycles
// ST_PREEMPT | grant held, REL asserted until owner drops
module arb_rr_scheduler #(
  parameter int C_NUM_REQ  = 4,
  parameter int C_MAX_HOLD = 256
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [C_NUM_REQ-1:0]         s_req,
  output logic [C_NUM_REQ-1:0]         s_gnt,
  output logic [C_NUM_REQ-1:0]         s_rel,
  output logic                         busy,
  output logic [$clog2(C_NUM_REQ)-1:0] owner
);

  localparam int C_OW = $clog2(C_NUM_REQ);
  localparam int C_HW = (C_MAX_HOLD > 0) ? $clog2(C_MAX_HOLD + 1) : 1;
  localparam logic [C_HW-1:0] C_HOLD_LAST = C_HW'((C_MAX_HOLD > 0) ? C_MAX_HOLD - 1 : 0);
  localparam logic [C_HW-1:0] C_HOLD_SAT  = C_HW'(C_MAX_HOLD);
  localparam logic [C_OW:0]   C_N_EXT     = (C_OW + 1)'(C_NUM_REQ);
  localparam logic [C_OW-1:0] C_LAST_IDX  = C_OW'(C_NUM_REQ - 1);
  localparam logic            C_PREEMPT_EN = (C_MAX_HOLD > 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_PREEMPT = 2'd2
  } state_t;

  state_t                r_state;
  logic [C_NUM_REQ-1:0]  r_gnt;
  logic [C_NUM_REQ-1:0]  r_rel;
  logic [C_OW-1:0]       r_owner;
  logic [C_OW-1:0]       r_ptr;
  logic [C_HW-1:0]       r_hold;

  state_t                w_nxt_state;
  logic [C_NUM_REQ-1:0]  w_nxt_gnt;
  logic [C_NUM_REQ-1:0]  w_nxt_rel;
  logic [C_OW-1:0]       w_nxt_owner;
  logic [C_OW-1:0]       w_nxt_ptr;
  logic [C_HW-1:0]       w_nxt_hold;

  logic [C_NUM_REQ-1:0]  w_req_rot;
  logic [C_OW-1:0]       w_off;
  logic [C_OW:0]         w_sel_sum;
  logic [C_OW-1:0]       w_sel;
  logic [C_OW-1:0]       w_sel_inc;
  logic [C_NUM_REQ-1:0]  w_sel_oh;
  logic                  w_any_req;
  logic                  w_others;

  // Rotate requests so that bit 0 corresponds to r_ptr; first set bit is the winner.
  assign w_req_rot = C_NUM_REQ'({s_req, s_req} >> r_ptr);
  assign w_any_req = |s_req;
  assign w_others  = |(s_req & ~r_gnt);

  always_comb begin
    w_off = '0;
    for (int i = C_NUM_REQ - 1; i >= 0; i--) begin
      if (w_req_rot[i]) w_off = C_OW'(i);
    end
  end

  always_comb begin
    w_sel_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_sel     = (w_sel_sum >= C_N_EXT) ? C_OW'(w_sel_sum - C_N_EXT) : C_OW'(w_sel_sum);
    w_sel_inc = (w_sel == C_LAST_IDX) ? '0 : w_sel + 1'b1;
    w_sel_oh  = '0;
    w_sel_oh[w_sel] = 1'b1;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_rel   = r_rel;
    w_nxt_owner = r_owner;
    w_nxt_ptr   = r_ptr;
    w_nxt_hold  = r_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_nxt_gnt   = w_sel_oh;
          w_nxt_owner = w_sel;
          w_nxt_ptr   = w_sel_inc;
          w_nxt_hold  = '0;
          w_nxt_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!s_req[r_owner]) begin
          w_nxt_gnt   = '0;
          w_nxt_state = ST_IDLE;
        end else if (w_others && C_PREEMPT_EN) begin
          // Counter only advances under contention and freezes otherwise.
          if (r_hold == C_HOLD_LAST) begin
            w_nxt_rel   = r_gnt;
            w_nxt_state = ST_PREEMPT;
          end else if (r_hold != C_HOLD_SAT) begin
            w_nxt_hold = r_hold + 1'b1;
          end
        end
      end
      ST_PREEMPT: begin
        if (!s_req[r_owner]) begin
          w_nxt_gnt   = '0;
          w_nxt_rel   = '0;
          w_nxt_state = ST_IDLE;
        end
      end
      default: begin
        w_nxt_gnt   = '0;
        w_nxt_rel   = '0;
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_rel   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_rel   <= w_nxt_rel;
      r_owner <= w_nxt_owner;
      r_ptr   <= w_nxt_ptr;
      r_hold  <= w_nxt_hold;
    end
  end

  assign s_gnt = r_gnt;
  assign s_rel = r_rel;
  assign busy  = |r_gnt;
  assign owner = r_owner;

endmodule

// File: tb/tb_arb_rr_scheduler.sv
// Bench for arb_rr_scheduler: directed scenarios plus random traffic, every cycle
// compared against a behavioural arbitration model.
module tb_arb_rr_scheduler;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         aclk;
  logic         areset;
  logic [N-1:0] s_req;
  logic [N-1:0] s_gnt;
  logic [N-1:0] s_rel;
  logic         busy;
  logic [1:0]   owner;

  int n_vec = 0;
  int n_err = 0;

  bit m_busy;
  bit m_rel;
  int m_owner;
  int m_ptr;
  int m_held;

  arb_rr_scheduler #(.C_NUM_REQ(N), .C_MAX_HOLD(MAXH)) dut (
    .aclk   (aclk),
    .areset (areset),
    .s_req  (s_req),
    .s_gnt  (s_gnt),
    .s_rel  (s_rel),
    .busy   (busy),
    .owner  (owner)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Arbitration rules at transaction level: who owns, how long contended, REL issued.
  task automatic model_step();
    if (areset) begin
      m_busy = 0; m_rel = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      if (s_req != '0) begin
        bit found;
        found = 0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (!found && s_req[idx]) begin
            found   = 1;
            m_busy  = 1;
            m_rel   = 0;
            m_owner = idx;
            m_ptr   = (idx + 1) % N;
            m_held  = 0;
          end
        end
      end
    end else if (!s_req[m_owner]) begin
      m_busy = 0;
      m_rel  = 0;
    end else if (!m_rel && MAXH > 0) begin
      int others;
      others = 0;
      for (int k = 0; k < N; k++) if (k != m_owner && s_req[k]) others++;
      if (others > 0) begin
        m_held++;
        if (m_held >= MAXH) m_rel = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    logic [N-1:0] er;
    eg = '0;
    er = '0;
    if (m_busy) begin
      eg[m_owner] = 1'b1;
      if (m_rel) er[m_owner] = 1'b1;
    end
    chk("gnt",   32'(s_gnt), 32'(eg));
    chk("rel",   32'(s_rel), 32'(er));
    chk("busy",  32'(busy),  32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
  endtask

  task automatic tick();
    @(posedge aclk);
    model_step();
    @(negedge aclk);
    check_all();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    s_req  = '0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  initial begin
    int w;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    areset = 1'b1;
    s_req  = '0;
    m_busy = 0; m_rel = 0; m_owner = 0; m_ptr = 0; m_held = 0;
    @(negedge aclk);
    do_reset();
    chk("rst_gnt",   32'(s_gnt), 0);
    chk("rst_owner", 32'(owner), 0);

    // single requester
    s_req = 4'b0001;
    tick();
    chk("single_gnt", 32'(s_gnt), 32'h1);
    repeat (4) tick();
    s_req = 4'b0000;
    tick();
    chk("single_drop", 32'(s_gnt), 0);
    chk("single_owner", 32'(owner), 0);
    repeat (2) tick();

    // round robin with all requesting
    do_reset();
    s_req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (s_gnt == '0 && w < 20) begin
        tick();
        w++;
      end
      chk("rr_wait", 32'(s_gnt != '0), 1);
      chk("rr_order", 32'(owner), 32'(exp_order[g]));
      repeat (2) tick();
      s_req[owner] = 1'b0;
      tick();
      chk("rr_gap", 32'(s_gnt), 0);
      s_req = 4'b1111;
    end
    s_req = '0;
    repeat (2) tick();

    // preemption
    do_reset();
    s_req = 4'b0001;
    tick();
    chk("pre_gnt0", 32'(s_gnt), 32'h1);
    s_req = 4'b0101;
    w = 0;
    while (s_rel == '0 && w < 20) begin
      tick();
      w++;
    end
    chk("rel_latency", 32'(w), 32'(MAXH));
    repeat (2) tick();
    s_req = 4'b0100;
    tick();
    chk("pre_gnt_clr", 32'(s_gnt), 0);
    chk("pre_rel_clr", 32'(s_rel), 0);
    tick();
    chk("pre_next", 32'(s_gnt), 32'h4);
    s_req = '0;
    repeat (2) tick();

    // no contention: long hold, no REL
    s_req = 4'b0010;
    repeat (1000) tick();
    chk("long_gnt", 32'(s_gnt), 32'h2);
    chk("long_rel", 32'(s_rel), 0);
    s_req = '0;
    repeat (2) tick();

    // reset while owner 3 is being preempted
    s_req = 4'b1000;
    tick();
    s_req = 4'b1001;
    w = 0;
    while (s_rel == '0 && w < 20) begin
      tick();
      w++;
    end
    chk("rst_pre_rel", 32'(s_rel), 32'h8);
    areset = 1'b1;
    tick();
    chk("midrst_gnt",   32'(s_gnt), 0);
    chk("midrst_rel",   32'(s_rel), 0);
    chk("midrst_busy",  32'(busy),  0);
    chk("midrst_owner", 32'(owner), 0);
    areset = 1'b0;
    s_req  = 4'b1010;
    tick();
    chk("midrst_next", 32'(s_gnt), 32'h2);

    // owner 1 drops while 0 and 2 rise together
    s_req = 4'b0010;
    repeat (2) tick();
    s_req = 4'b0101;
    tick();
    chk("simul_gap", 32'(s_gnt), 0);
    tick();
    chk("simul_next", 32'(s_gnt), 32'h4);
    s_req = '0;
    repeat (2) tick();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] r;
      r = s_req;
      for (int i = 0; i < N; i++) begin
        if (m_busy && i == m_owner && r[i]) begin
          if ($urandom_range(m_rel ? 2 : 7, 0) == 0) r[i] = 1'b0;
        end else if (r[i]) begin
          if ($urandom_range(15, 0) == 0) r[i] = 1'b0;
        end else begin
          if ($urandom_range(3, 0) == 0) r[i] = 1'b1;
        end
      end
      s_req  = r;
      areset = ($urandom_range(499, 0) == 0);
      tick();
    end
    areset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
